// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared state type and arithmetic helpers for the FIFO burst scheduler.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_ERR
    } state_t;

    // A zero burst length still moves one word.
    function automatic logic [31:0] eff_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_sched_timer.sv
// fifo_sched_timer: saturating up-counter with synchronous clear and active-low reset.
module fifo_sched_timer
    import fifo_sched_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= W'(sat_inc(32'(r_cnt), 32'(MAX)));
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fifo_burst_sched.sv
// fifo_burst_sched: pops bursts from a FIFO onto a valid/ready stream, with a timeout
// that flushes partial bursts and an error state that halts popping until cleared.
module fifo_burst_sched
    import fifo_sched_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4,
    parameter int TMO_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] burst_len,
    input  logic [TMO_WIDTH-1:0] timeout,
    input  logic                 err_clr,
    input  logic [CNT_WIDTH-1:0] fifo_word_cnt,
    input  logic                 fifo_empty,
    input  logic                 fifo_error,
    input  logic [WIDTH-1:0]     fifo_data_out,
    output logic                 fifo_pop_n,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 burst_done,
    output logic                 error
);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_beats;
    logic                 r_done;
    logic [TMO_WIDTH-1:0] w_timer;
    logic [CNT_WIDTH-1:0] w_eff;
    logic [CNT_WIDTH-1:0] w_part;
    logic                 w_in_wait;
    logic                 w_xfer;
    logic                 w_final;
    logic                 w_full_go;
    logic                 w_part_go;

    assign w_eff     = CNT_WIDTH'(eff_len(32'(burst_len)));
    assign w_part    = CNT_WIDTH'(eff_len(32'(fifo_word_cnt)));
    assign w_in_wait = (r_state == S_WAIT);

    // Timer only runs while waiting on a non-empty FIFO; any other state holds it at zero.
    fifo_sched_timer #(.W(TMO_WIDTH)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (!w_in_wait || fifo_empty),
        .i_inc (!fifo_empty),
        .o_cnt (w_timer)
    );

    // Gating with rst_n keeps the stream quiet and blocks a pop on the reset edge itself.
    assign out_valid  = rst_n && (r_state == S_BURST) && !fifo_empty;
    assign w_xfer     = out_valid && out_ready;
    assign w_final    = w_xfer && (r_beats == CNT_WIDTH'(1));
    assign fifo_pop_n = !w_xfer;
    assign out_data   = fifo_data_out;
    assign out_last   = out_valid && (r_beats == CNT_WIDTH'(1));
    assign busy       = rst_n && (r_state == S_BURST);
    assign error      = rst_n && (r_state == S_ERR);
    assign burst_done = r_done;

    assign w_full_go = (fifo_word_cnt >= w_eff);
    assign w_part_go = (timeout != '0) && !fifo_empty && (w_timer >= timeout);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_beats <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_final;
            if (w_xfer && (r_beats != '0))
                r_beats <= r_beats - CNT_WIDTH'(1);
            if (fifo_error)
                r_state <= S_ERR;
            else begin
                case (r_state)
                    S_IDLE:  if (enable) r_state <= S_WAIT;
                    S_WAIT: begin
                        if (!enable)
                            r_state <= S_IDLE;
                        else if (w_full_go) begin
                            r_state <= S_BURST;
                            r_beats <= w_eff;
                        end else if (w_part_go) begin
                            r_state <= S_BURST;
                            r_beats <= w_part;
                        end
                    end
                    S_BURST: if (w_final) r_state <= enable ? S_WAIT : S_IDLE;
                    S_ERR:   if (err_clr) r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_sched.sv
// tb_fifo_burst_sched: directed and random checks of the burst scheduler against a
// cycle-level reference model driven by a queue-based FIFO.
module tb_fifo_burst_sched;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_BURST = 2;
    localparam int M_ERR   = 3;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] burst_len;
    logic [7:0] timeout;
    logic       err_clr;
    logic [3:0] fifo_word_cnt;
    logic       fifo_empty;
    logic       fifo_error;
    logic [7:0] fifo_data_out;
    logic       fifo_pop_n;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       burst_done;
    logic       error;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] q[$];
    logic [7:0] got_q[$];
    int         m_mode, m_left, m_timer;
    bit         m_done;

    fifo_burst_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .burst_len     (burst_len),
        .timeout       (timeout),
        .err_clr       (err_clr),
        .fifo_word_cnt (fifo_word_cnt),
        .fifo_empty    (fifo_empty),
        .fifo_error    (fifo_error),
        .fifo_data_out (fifo_data_out),
        .fifo_pop_n    (fifo_pop_n),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .burst_done    (burst_done),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_word_cnt = 4'(q.size());
        fifo_empty    = (q.size() == 0);
        fifo_data_out = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] v);
        if (q.size() < 15) q.push_back(v);
        drive_fifo();
    endtask

    // Check outputs against the model, then advance model and FIFO across one clock edge.
    task automatic cycle();
        bit ev, xfer, pop, ndone;
        int eff, nmode, nleft, ntimer;
        #1;
        ev   = rst_n && (m_mode == M_BURST) && (q.size() > 0);
        xfer = ev && out_ready;
        chk("pop_n", fifo_pop_n, !xfer);
        chk("out_valid", out_valid, ev);
        chk("out_last", out_last, ev && (m_left == 1));
        chk("busy", busy, rst_n && (m_mode == M_BURST));
        chk("error", error, rst_n && (m_mode == M_ERR));
        chk("burst_done", burst_done, m_done);
        if (ev) chk("out_data", out_data, q[0]);
        eff    = (burst_len == 0) ? 1 : int'(burst_len);
        ntimer = (m_mode == M_WAIT && q.size() > 0) ? ((m_timer < 255) ? m_timer + 1 : 255) : 0;
        nmode  = m_mode;
        nleft  = xfer ? m_left - 1 : m_left;
        ndone  = xfer && (m_left == 1);
        if (!rst_n) begin
            nmode = M_IDLE; nleft = 0; ntimer = 0; ndone = 0;
        end else if (fifo_error)
            nmode = M_ERR;
        else if (m_mode == M_IDLE) begin
            if (enable) nmode = M_WAIT;
        end else if (m_mode == M_WAIT) begin
            if (!enable) nmode = M_IDLE;
            else if (q.size() >= eff) begin
                nmode = M_BURST; nleft = eff;
            end else if (timeout != 0 && q.size() > 0 && m_timer >= int'(timeout)) begin
                nmode = M_BURST; nleft = q.size();
            end
        end else if (m_mode == M_BURST) begin
            if (ndone) nmode = enable ? M_WAIT : M_IDLE;
        end else if (err_clr)
            nmode = M_IDLE;
        pop = (fifo_pop_n === 1'b0);
        @(posedge clk);
        m_mode = nmode; m_left = nleft; m_timer = ntimer; m_done = ndone;
        if (pop && q.size() > 0) got_q.push_back(q.pop_front());
        @(negedge clk);
        drive_fifo();
    endtask

    initial begin
        rst_n = 0; enable = 0; burst_len = 4; timeout = 0; err_clr = 0;
        fifo_error = 0; out_ready = 1;
        drive_fifo();
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_mode = M_IDLE; m_left = 0; m_timer = 0; m_done = 0;
        cycle();
        rst_n = 1;
        // Full burst of four
        enable = 1;
        cycle();
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        repeat (8) cycle();
        chk("t1_pops", got_q.size(), 4);
        if (got_q.size() == 4) for (int i = 0; i < 4; i++) chk("t1_data", got_q[i], 8'h10 + i);
        // Partial burst via timeout
        got_q.delete();
        burst_len = 8; timeout = 5;
        for (int i = 0; i < 3; i++) push(8'(8'h20 + i));
        repeat (12) cycle();
        chk("t2_pops", got_q.size(), 3);
        // Ready toggling
        got_q.delete();
        burst_len = 4; timeout = 0;
        for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
        for (int i = 0; i < 12; i++) begin
            out_ready = !(i & 1);
            cycle();
        end
        out_ready = 1;
        chk("t3_pops", got_q.size(), 4);
        if (got_q.size() == 4) for (int i = 0; i < 4; i++) chk("t3_data", got_q[i], 8'hA0 + i);
        // Enable dropped on beat 2
        got_q.delete();
        for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
        for (int i = 0; i < 20; i++) begin
            if (got_q.size() >= 1) enable = 0;
            cycle();
        end
        chk("t4_pops", got_q.size(), 4);
        got_q.delete();
        for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
        repeat (6) cycle();
        chk("t4_idle_pops", got_q.size(), 0);
        // Error mid-burst
        enable = 1;
        for (int i = 0; i < 10 && got_q.size() < 1; i++) cycle();
        fifo_error = 1;
        cycle();
        fifo_error = 0;
        repeat (3) cycle();
        chk("t5_err", error, 1);
        chk("t5_pops", got_q.size(), 2);
        err_clr = 1;
        cycle();
        err_clr = 0;
        cycle();
        chk("t5_clr", error, 0);
        enable = 0;
        cycle();
        q.delete();
        drive_fifo();
        cycle();
        // Reset on beat 2
        got_q.delete();
        enable = 1;
        for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
        for (int i = 0; i < 10 && got_q.size() < 1; i++) cycle();
        rst_n = 0;
        cycle();
        rst_n = 1;
        chk("t6_pops", got_q.size(), 1);
        cycle();
        chk("t6_done", burst_done, 0);
        repeat (3) cycle();
        enable = 0;
        cycle();
        q.delete();
        drive_fifo();
        cycle();
        // Zero burst length behaves as one
        got_q.delete();
        burst_len = 0; enable = 1;
        push(8'h66);
        repeat (5) cycle();
        chk("t7_pops", got_q.size(), 1);
        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) burst_len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0)
                timeout = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
            enable     = ($urandom_range(0, 9) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            fifo_error = ($urandom_range(0, 59) == 0);
            err_clr    = ($urandom_range(0, 3) == 0);
            rst_n      = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_burst_sched.md
FIFO_BURST_SCHED -- requirements
Module: fifo_burst_sched

Interface
REQ-001 Parameter WIDTH, 8, data width of the FIFO read path.
REQ-002 Parameter CNT_WIDTH, 4, width of FIFO word count and burst length.
REQ-003 Parameter TMO_WIDTH, 8, width of the partial-burst timeout counter.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port enable  in  1  scheduler enable; level-sensitive.
REQ-007 Port burst_len  in  CNT_WIDTH  target beats per burst; value 0 treated as 1.
REQ-008 Port timeout  in  TMO_WIDTH  non-empty cycles before a partial burst; 0 disables partial bursts.
REQ-009 Port err_clr  in  1  single-cycle clear of the error state.
REQ-010 Port fifo_word_cnt  in  CNT_WIDTH  FIFO occupancy.
REQ-011 Port fifo_empty  in  1  FIFO empty flag.
REQ-012 Port fifo_error  in  1  FIFO error flag.
REQ-013 Port fifo_data_out  in  WIDTH  FIFO head word, valid whenever fifo_empty=0.
REQ-014 Port fifo_pop_n  out  1  active-low pop to the FIFO.
REQ-015 Port out_valid / out_ready / out_data[WIDTH] / out_last  out/in/out/out  downstream valid-ready stream.
REQ-016 Port busy  out  1  high in state BURST.
REQ-017 Port burst_done  out  1  one-cycle pulse after the last beat of a burst.
REQ-018 Port error  out  1  high in state ERR.

Function
REQ-019 FSM states: IDLE, WAIT, BURST, ERR.
REQ-020 IDLE: enable=1 -> WAIT with the timer cleared.
REQ-021 WAIT: enable=0 -> IDLE; timer increments (saturating) each cycle fifo_empty=0 and clears when fifo_empty=1.
REQ-022 WAIT: fifo_word_cnt >= eff_len (eff_len = max(burst_len,1)) -> BURST with beats_left=eff_len; this takes priority over the timeout.
REQ-023 WAIT: timeout!=0, fifo_empty=0, timer>=timeout -> BURST with beats_left=fifo_word_cnt (partial burst).
REQ-024 burst_len and the partial count are sampled only on entry to BURST; changes during BURST are ignored.
REQ-025 BURST: out_valid = ~fifo_empty; out_data = fifo_data_out (combinational, zero latency).
REQ-026 Transfer = out_valid & out_ready; fifo_pop_n = ~transfer in the same cycle; fifo_pop_n is 1 in all other states.
REQ-027 out_last = (beats_left==1) & out_valid.
REQ-028 Each transfer decrements beats_left; out_valid stalls low if the FIFO goes empty mid-burst.
REQ-029 Final transfer: burst_done=1 the next cycle, timer cleared; next state WAIT if enable=1, else IDLE.
REQ-030 enable deasserted mid-burst: the burst completes before leaving BURST.
REQ-031 fifo_error=1 in any state -> ERR next cycle; a pending transfer in that same cycle still completes.
REQ-032 ERR: out_valid=0, fifo_pop_n=1; err_clr=1 -> IDLE; fifo_error overrides err_clr.
REQ-033 beats_left is CNT_WIDTH wide and never underflows; the timer saturates at all-ones.

Reset
REQ-034 rst_n=0 at a clock edge -> state IDLE, timer=0, beats_left=0, burst_done=0, from that edge onward.
REQ-035 Outputs during and after reset: fifo_pop_n=1, out_valid=0, out_last=0, busy=0, error=0.
REQ-036 Reset mid-burst aborts the burst: no burst_done, and no pop on the reset edge.

Structure
REQ-037 The state enum and the eff_len / saturating-increment helpers belong in the shared package fifo_sched_pkg.
REQ-038 One sub-module, fifo_sched_timer (saturating counter with clear), is natural; the FSM and datapath stay in the top.

Verification
REQ-039 burst_len=4, timeout=0, push 4 words, out_ready=1 -> 4 consecutive pops, out_last on beat 4, burst_done 1 cycle later.
REQ-040 burst_len=8, timeout=5, 3 words held -> BURST after the 5th non-empty cycle, 3 beats, out_last on beat 3.
REQ-041 burst_len=4, out_ready toggling 1/0 -> exactly 4 pops, fifo_pop_n=1 on every ready-low cycle, data order preserved.
REQ-042 enable dropped on beat 2 of 4 -> burst completes, then IDLE, no further pops.
REQ-043 fifo_error pulse mid-burst -> ERR, pops stop, error=1; err_clr -> IDLE.
REQ-044 rst_n low on beat 2 -> next cycle IDLE, fifo_pop_n=1, no burst_done.
